// File: rtl/pwm_capture.sv
// PWM receiver: synchronises pwm_in, measures high time and rise-to-rise period
// in prescaler ticks, and flags a stuck line after TIMEOUT_TICKS without edges.
module pwm_capture #(
    parameter int DVSR          = 19,
    parameter int TIMEOUT_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pwm_in,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic [8:0] period,
    output logic       period_valid,
    output logic       stuck
);

    // state | meaning
    // IDLE  | no measurement in progress (after reset, disable or timeout)
    // HIGH  | line high after a counted rise, accumulating high time
    // LOW   | line low after a counted fall, waiting for the closing rise
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam int PW = (DVSR < 2) ? 1 : $clog2(DVSR + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(DVSR);
    localparam logic [PW-1:0] PRE_HALF = PW'((DVSR + 1) / 2);
    localparam logic [8:0]    TO_CNT   = 9'(TIMEOUT_TICKS);

    state_t        state, state_nxt;
    logic          s1, s2, s3;
    logic [PW-1:0] pre_cnt, pre_inc;
    logic [7:0]    hi_cnt;
    logic [8:0]    per_cnt;
    logic [8:0]    idle_cnt;
    logic          rise, fall, edge_det, tick, round_up, timeout;
    logic [9:0]    hi_sum;
    logic [10:0]   per_sum;
    logic [7:0]    duty_meas;
    logic [8:0]    per_meas;
    logic          pub_duty, pub_period, pub_to, start;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign edge_det = rise | fall;
    assign tick     = (pre_cnt == PRE_MAX);
    assign pre_inc  = tick ? '0 : pre_cnt + PW'(1);
    assign timeout  = (idle_cnt == TO_CNT) && !edge_det;

    // The edge cycle is the first clock of a new interval, so measurements include
    // a tick landing on the closing edge and round on the post-increment phase.
    assign round_up  = (pre_inc >= PRE_HALF);
    assign hi_sum    = 10'(hi_cnt) + 10'(tick) + 10'(round_up);
    assign per_sum   = 11'(per_cnt) + 11'(tick) + 11'(round_up);
    assign duty_meas = (hi_sum > 10'd255) ? 8'hFF : hi_sum[7:0];
    assign per_meas  = (per_sum > 11'd511) ? 9'h1FF : per_sum[8:0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ena || timeout) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = HIGH;
                HIGH:    if (fall) state_nxt = LOW;
                LOW:     if (rise) state_nxt = HIGH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pub_duty   = 1'b0;
        pub_period = 1'b0;
        pub_to     = 1'b0;
        start      = 1'b0;
        if (ena) begin
            pub_to = timeout;
            case (state)
                IDLE: start = rise;
                HIGH: pub_duty = fall;
                LOW: begin
                    pub_period = rise;
                    start      = rise;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pre_cnt  <= '0;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
            stuck    <= 1'b0;
        end else if (!ena) begin
            pre_cnt  <= '0;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
            stuck    <= 1'b0;
        end else begin
            pre_cnt <= edge_det ? '0 : pre_inc;

            if (edge_det || timeout)       idle_cnt <= '0;
            else if (tick && idle_cnt != 9'h1FF) idle_cnt <= idle_cnt + 9'd1;

            if (start)                                         hi_cnt <= '0;
            else if (state == HIGH && tick && hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;

            if (start)                                           per_cnt <= '0;
            else if (state != IDLE && tick && per_cnt != 9'h1FF) per_cnt <= per_cnt + 9'd1;

            if (edge_det)     stuck <= 1'b0;
            else if (timeout) stuck <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            duty         <= '0;
            duty_valid   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            duty_valid   <= pub_duty | pub_to;
            period_valid <= pub_period;
            if (pub_to)        duty <= s2 ? 8'hFF : 8'h00;
            else if (pub_duty) duty <= duty_meas;
            if (pub_period)    period <= per_meas;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: loopback frames, duty extremes, rounding,
// enable/reset mid-frame, glitch recovery and stuck-line timeouts.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] duty;
    logic       duty_valid;
    logic [8:0] period;
    logic       period_valid;
    logic       stuck;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int dv_cnt, pv_cnt, dv_cyc_prev, dv_cyc_last, fall_start;
    logic [7:0] last_duty;
    logic [8:0] last_period;

    pwm_capture dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
        .duty(duty), .duty_valid(duty_valid), .period(period),
        .period_valid(period_valid), .stuck(stuck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        dv_cnt = 0;
        pv_cnt = 0;
        dv_cyc_prev = 0;
        dv_cyc_last = 0;
    endtask

    // Drive a level for n clocks; observe outputs 1 time unit after each rising edge.
    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = lvl;
            @(posedge clk);
            #1;
            cyc++;
            if (duty_valid === 1'b1) begin
                dv_cnt++;
                last_duty   = duty;
                dv_cyc_prev = dv_cyc_last;
                dv_cyc_last = cyc;
            end
            if (period_valid === 1'b1) begin
                pv_cnt++;
                last_period = period;
            end
        end
    endtask

    task automatic frame(input int hi, input int lo);
        hold(1'b1, hi);
        fall_start = cyc;
        hold(1'b0, lo);
    endtask

    initial begin
        clr_counts();
        last_duty = '0;
        last_period = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_duty", 32'(duty), 0);
        chk("reset_period", 32'(period), 0);
        chk("reset_valids", 32'({duty_valid, period_valid}), 0);
        chk("reset_stuck", 32'(stuck), 0);

        rst_n = 1'b0;
        ena   = 1'b1;
        hold(1'b0, 4);

        // loopback, ui_in=128
        clr_counts();
        repeat (3) frame(2560, 2560);
        chk("mid_duty", 32'(last_duty), 128);
        chk("mid_period", 32'(last_period), 256);
        chk("mid_dv_count", 32'(dv_cnt), 3);
        chk("mid_pv_count", 32'(pv_cnt), 2);
        chk("mid_latency", 32'(dv_cyc_last - fall_start), 3);
        chk("mid_stuck", 32'(stuck), 0);

        // duty extremes
        repeat (2) frame(20, 5100);
        chk("min_duty", 32'(duty), 1);
        chk("min_period", 32'(period), 256);
        repeat (2) frame(5100, 20);
        chk("max_duty", 32'(duty), 255);
        chk("max_period", 32'(period), 256);

        // rounding at N=50
        frame(1009, 1000);
        chk("round_down", 32'(duty), 50);
        frame(1010, 1000);
        chk("round_up", 32'(duty), 51);
        frame(1000, 1000);
        hold(1'b1, 500);
        chk("exact_period", 32'(period), 100);

        // enable dropped during HIGH
        ena = 1'b0;
        clr_counts();
        hold(1'b1, 100);
        chk("dis_no_valid", 32'(dv_cnt + pv_cnt), 0);
        ena = 1'b1;
        hold(1'b1, 500);
        hold(1'b0, 1000);
        chk("reen_fall_unpub", 32'(dv_cnt), 0);
        chk("reen_duty_hold", 32'(duty), 50);
        frame(1500, 1500);
        hold(1'b1, 20);
        chk("reen_duty", 32'(duty), 75);
        chk("reen_period", 32'(period), 150);
        hold(1'b0, 1000);

        // 1-clock glitch, then clean frames
        hold(1'b1, 1);
        hold(1'b0, 600);
        repeat (2) frame(600, 400);
        hold(1'b1, 5);
        chk("glitch_duty", 32'(duty), 30);
        chk("glitch_period", 32'(period), 50);

        // stuck low: fall publish then two timeouts
        clr_counts();
        hold(1'b0, 13000);
        chk("low_dv_count", 32'(dv_cnt), 3);
        chk("low_interval", 32'(dv_cyc_last - dv_cyc_prev), 6000);
        chk("low_duty", 32'(last_duty), 0);
        chk("low_stuck", 32'(stuck), 1);

        // stuck high with saturation
        hold(1'b1, 10);
        chk("rise_clears_stuck", 32'(stuck), 0);
        clr_counts();
        hold(1'b1, 8190);
        chk("high_dv_count", 32'(dv_cnt), 1);
        chk("high_duty", 32'(duty), 255);
        chk("high_stuck", 32'(stuck), 1);
        clr_counts();
        hold(1'b0, 100);
        chk("idle_fall_unpub", 32'(dv_cnt), 0);
        chk("idle_fall_stuck", 32'(stuck), 0);
        chk("idle_fall_duty", 32'(duty), 255);

        // asynchronous reset mid-frame
        hold(1'b1, 300);
        rst_n = 1'b1;
        #1;
        chk("arst_duty", 32'(duty), 0);
        chk("arst_period", 32'(period), 0);
        chk("arst_stuck", 32'(stuck), 0);
        rst_n = 1'b0;
        hold(1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
